data_mem_arbiter: RTL and testbench

Two-port arbiter that shares the single-ported synchronous data memory between two requesters: port 0 is the CPU load/store stage, port 1 is the program/data loader or debug port. It accepts one request per cycle via a valid/ready handshake, drives the memory's address/write_data/MemWrite/MemRead strobes, and returns a one-cycle response pulse (with read data for loads) to the port that issued the request. Arbitration is round-robin or fixed-priority, selected by parameter.

---
 rtl/data_mem_arbiter.sv | 139 +++++++++++++
 tb/tb_data_mem_arbiter.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : data_mem_arbiter
// Function : Shares one single-ported synchronous data memory between the CPU
//            load/store stage (port 0) and the loader/debug port (port 1).
//            Round-robin or fixed-priority grant, valid/ready requests and a
//            one-cycle response pulse carrying load data back to the winner.
// Revision : 1.0 - initial release
// ============================================================================
module data_mem_arbiter #(
    parameter bit RR_ENABLE = 1'b1
) (
    input  logic        CLK,
    input  logic        reset,
    input  logic        req0_valid,
    input  logic        req0_write,
    input  logic [31:0] req0_addr,
    input  logic [31:0] req0_wdata,
    output logic        req0_ready,
    input  logic        req1_valid,
    input  logic        req1_write,
    input  logic [31:0] req1_addr,
    input  logic [31:0] req1_wdata,
    output logic        req1_ready,
    output logic        rsp0_valid,
    output logic [31:0] rsp0_rdata,
    output logic        rsp1_valid,
    output logic [31:0] rsp1_rdata,
    output logic [31:0] mem_address,
    output logic [31:0] mem_write_data,
    output logic        mem_MemWrite,
    output logic        mem_MemRead,
    input  logic [31:0] mem_read_data
);

    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    state_t      state_q;
    logic        last_grant_q;   // 1 = port 1 won the most recent handshake
    logic        pend_port_q;    // port owning the load currently in RD_WAIT
    logic        rsp0_valid_q;
    logic        rsp1_valid_q;
    logic [31:0] rsp0_rdata_q;
    logic [31:0] rsp1_rdata_q;

    logic        w_idle;
    logic        w_gnt0;
    logic        w_gnt1;
    logic        w_write;

    assign w_idle = (state_q == IDLE);

    // Grant selection: only in IDLE; contention resolved by policy and history
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (w_idle) begin
            if (req0_valid && req1_valid) begin
                if (RR_ENABLE && !last_grant_q) begin
                    w_gnt1 = 1'b1;
                end else begin
                    w_gnt0 = 1'b1;
                end
            end else begin
                w_gnt0 = req0_valid;
                w_gnt1 = req1_valid;
            end
        end
    end

    assign w_write    = w_gnt1 ? req1_write : req0_write;

    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Memory strobes come straight from the granted request; all zero otherwise
    assign mem_address    = w_gnt0 ? req0_addr  : (w_gnt1 ? req1_addr  : 32'd0);
    assign mem_write_data = w_gnt0 ? req0_wdata : (w_gnt1 ? req1_wdata : 32'd0);
    assign mem_MemWrite   = (w_gnt0 && req0_write)  || (w_gnt1 && req1_write);
    assign mem_MemRead    = (w_gnt0 && !req0_write) || (w_gnt1 && !req1_write);

    // Arbiter FSM: tracks the outstanding load and produces registered responses
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            last_grant_q <= 1'b1;
            pend_port_q  <= 1'b0;
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            rsp0_rdata_q <= 32'd0;
            rsp1_rdata_q <= 32'd0;
        end else begin
            rsp0_valid_q <= 1'b0;
            rsp1_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (w_gnt0 || w_gnt1) begin
                        last_grant_q <= w_gnt1;
                        if (w_write) begin
                            // Store completes as soon as memory samples it
                            if (w_gnt1) begin
                                rsp1_valid_q <= 1'b1;
                                rsp1_rdata_q <= 32'd0;
                            end else begin
                                rsp0_valid_q <= 1'b1;
                                rsp0_rdata_q <= 32'd0;
                            end
                        end else begin
                            pend_port_q <= w_gnt1;
                            state_q     <= RD_WAIT;
                        end
                    end
                end
                RD_WAIT: begin
                    // Memory output is valid now; capture it for the owner
                    state_q <= IDLE;
                    if (pend_port_q) begin
                        rsp1_valid_q <= 1'b1;
                        rsp1_rdata_q <= mem_read_data;
                    end else begin
                        rsp0_valid_q <= 1'b1;
                        rsp0_rdata_q <= mem_read_data;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign rsp0_valid = rsp0_valid_q;
    assign rsp1_valid = rsp1_valid_q;
    assign rsp0_rdata = rsp0_rdata_q;
    assign rsp1_rdata = rsp1_rdata_q;

endmodule
`default_nettype wire

// File: tb/tb_data_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_data_mem_arbiter
// Function : Directed self-checking bench for data_mem_arbiter. Instance a is
//            round-robin, instance b fixed-priority; each has a small
//            synchronous memory model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_data_mem_arbiter;

    logic CLK = 1'b0;
    logic reset = 1'b1;
    always #5 CLK = ~CLK;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // ---------------- instance a: round-robin ----------------
    logic        a_v0 = 0, a_w0 = 0, a_v1 = 0, a_w1 = 0;
    logic [31:0] a_ad0 = 0, a_wd0 = 0, a_ad1 = 0, a_wd1 = 0;
    logic        a_rdy0, a_rdy1, a_rsp0v, a_rsp1v, a_mw, a_mr;
    logic [31:0] a_rsp0d, a_rsp1d, a_maddr, a_mwdat;
    logic [31:0] a_rd = 0;
    logic [31:0] mem_a [0:15];

    data_mem_arbiter #(.RR_ENABLE(1'b1)) dut_rr (
        .CLK(CLK), .reset(reset),
        .req0_valid(a_v0), .req0_write(a_w0), .req0_addr(a_ad0), .req0_wdata(a_wd0),
        .req0_ready(a_rdy0),
        .req1_valid(a_v1), .req1_write(a_w1), .req1_addr(a_ad1), .req1_wdata(a_wd1),
        .req1_ready(a_rdy1),
        .rsp0_valid(a_rsp0v), .rsp0_rdata(a_rsp0d),
        .rsp1_valid(a_rsp1v), .rsp1_rdata(a_rsp1d),
        .mem_address(a_maddr), .mem_write_data(a_mwdat),
        .mem_MemWrite(a_mw), .mem_MemRead(a_mr), .mem_read_data(a_rd)
    );

    always @(posedge CLK) begin
        if (a_mw) mem_a[a_maddr[3:0]] <= a_mwdat;
        if (a_mr) a_rd <= mem_a[a_maddr[3:0]];
    end

    // ---------------- instance b: fixed priority ----------------
    logic        b_v0 = 0, b_w0 = 0, b_v1 = 0, b_w1 = 0;
    logic [31:0] b_ad0 = 0, b_wd0 = 0, b_ad1 = 0, b_wd1 = 0;
    logic        b_rdy0, b_rdy1, b_rsp0v, b_rsp1v, b_mw, b_mr;
    logic [31:0] b_rsp0d, b_rsp1d, b_maddr, b_mwdat;
    logic [31:0] b_rd = 0;
    logic [31:0] mem_b [0:15];

    data_mem_arbiter #(.RR_ENABLE(1'b0)) dut_fp (
        .CLK(CLK), .reset(reset),
        .req0_valid(b_v0), .req0_write(b_w0), .req0_addr(b_ad0), .req0_wdata(b_wd0),
        .req0_ready(b_rdy0),
        .req1_valid(b_v1), .req1_write(b_w1), .req1_addr(b_ad1), .req1_wdata(b_wd1),
        .req1_ready(b_rdy1),
        .rsp0_valid(b_rsp0v), .rsp0_rdata(b_rsp0d),
        .rsp1_valid(b_rsp1v), .rsp1_rdata(b_rsp1d),
        .mem_address(b_maddr), .mem_write_data(b_mwdat),
        .mem_MemWrite(b_mw), .mem_MemRead(b_mr), .mem_read_data(b_rd)
    );

    always @(posedge CLK) begin
        if (b_mw) mem_b[b_maddr[3:0]] <= b_mwdat;
        if (b_mr) b_rd <= mem_b[b_maddr[3:0]];
    end

    // Invariants sampled every cycle, mid-low-phase after inputs settle
    always begin
        @(negedge CLK);
        #2;
        chk("a_rw_excl",  {31'd0, a_mr & a_mw}, 32'd0);
        chk("a_rdy_excl", {31'd0, a_rdy0 & a_rdy1}, 32'd0);
        chk("a_rsp_excl", {31'd0, a_rsp0v & a_rsp1v}, 32'd0);
        chk("a_mem_quiet", (a_rdy0 | a_rdy1) ? 32'd0 : (a_maddr | a_mwdat | {30'd0, a_mw, a_mr}), 32'd0);
        chk("b_rw_excl",  {31'd0, b_mr & b_mw}, 32'd0);
        chk("b_rdy_excl", {31'd0, b_rdy0 & b_rdy1}, 32'd0);
        chk("b_rsp_excl", {31'd0, b_rsp0v & b_rsp1v}, 32'd0);
        chk("b_mem_quiet", (b_rdy0 | b_rdy1) ? 32'd0 : (b_maddr | b_mwdat | {30'd0, b_mw, b_mr}), 32'd0);
    end

    initial begin
        logic exp_port;

        repeat (2) @(negedge CLK);
        reset = 1'b0;
        #1;
        // Reset state
        chk("rst_rdy0",  {31'd0, a_rdy0}, 32'd0);
        chk("rst_rdy1",  {31'd0, a_rdy1}, 32'd0);
        chk("rst_rsp0v", {31'd0, a_rsp0v}, 32'd0);
        chk("rst_rsp1v", {31'd0, a_rsp1v}, 32'd0);
        chk("rst_rsp0d", a_rsp0d, 32'd0);
        chk("rst_rsp1d", a_rsp1d, 32'd0);
        chk("rst_mw",    {31'd0, a_mw}, 32'd0);

        // Port 0 store addr 3
        a_v0 = 1; a_w0 = 1; a_ad0 = 32'd3; a_wd0 = 32'hDEADBEEF;
        #1;
        chk("st_rdy0",  {31'd0, a_rdy0}, 32'd1);
        chk("st_mw",    {31'd0, a_mw}, 32'd1);
        chk("st_addr",  a_maddr, 32'd3);
        chk("st_wdata", a_mwdat, 32'hDEADBEEF);
        @(negedge CLK);
        // Load addr 3 right behind the store
        a_w0 = 0;
        #1;
        chk("st_rsp0v", {31'd0, a_rsp0v}, 32'd1);
        chk("st_rsp0d", a_rsp0d, 32'd0);
        chk("ld_rdy0",  {31'd0, a_rdy0}, 32'd1);
        chk("ld_mr",    {31'd0, a_mr}, 32'd1);
        @(negedge CLK);
        a_v0 = 0;
        #1;
        chk("ld_wait_rsp0v", {31'd0, a_rsp0v}, 32'd0);
        chk("ld_wait_mr",    {31'd0, a_mr}, 32'd0);
        @(negedge CLK);
        #1;
        chk("ld_rsp0v", {31'd0, a_rsp0v}, 32'd1);
        chk("ld_rsp0d", a_rsp0d, 32'hDEADBEEF);

        // Port 1 store addr 5
        a_v1 = 1; a_w1 = 1; a_ad1 = 32'd5; a_wd1 = 32'h11115555;
        #1;
        chk("st1_rdy1", {31'd0, a_rdy1}, 32'd1);
        @(negedge CLK);
        // Both ports load continuously: port 0 first (port 1 won last)
        a_w1 = 0;
        a_v0 = 1; a_w0 = 0; a_ad0 = 32'd3;
        #1;
        chk("st1_rsp1v", {31'd0, a_rsp1v}, 32'd1);
        chk("st1_rsp1d", a_rsp1d, 32'd0);
        exp_port = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("rr_rdy0", {31'd0, a_rdy0}, {31'd0, ~exp_port});
            chk("rr_rdy1", {31'd0, a_rdy1}, {31'd0, exp_port});
            @(negedge CLK);
            #1;
            chk("rr_wait_rdy", {30'd0, a_rdy0, a_rdy1}, 32'd0);
            chk("rr_wait_rsp", {30'd0, a_rsp0v, a_rsp1v}, 32'd0);
            @(negedge CLK);
            #1;
            chk("rr_rspv", exp_port ? {30'd0, a_rsp0v, a_rsp1v} : {30'd0, a_rsp0v, a_rsp1v},
                exp_port ? 32'd1 : 32'd2);
            chk("rr_rspd", exp_port ? a_rsp1d : a_rsp0d, exp_port ? 32'h11115555 : 32'hDEADBEEF);
            exp_port = ~exp_port;
        end
        a_v0 = 0; a_v1 = 0;

        // Port 1 load arrives while port 0 load is outstanding
        @(negedge CLK);
        a_v0 = 1; a_w0 = 0; a_ad0 = 32'd5;
        #1;
        chk("pend_rdy0", {31'd0, a_rdy0}, 32'd1);
        @(negedge CLK);
        a_v0 = 0;
        a_v1 = 1; a_w1 = 0; a_ad1 = 32'd3;
        #1;
        chk("pend_rdy1_wait", {31'd0, a_rdy1}, 32'd0);
        @(negedge CLK);
        #1;
        chk("pend_rsp0v", {31'd0, a_rsp0v}, 32'd1);
        chk("pend_rsp0d", a_rsp0d, 32'h11115555);
        chk("pend_rdy1",  {31'd0, a_rdy1}, 32'd1);
        @(negedge CLK);
        a_v1 = 0;
        #1;
        chk("pend_rsp1v_wait", {31'd0, a_rsp1v}, 32'd0);
        @(negedge CLK);
        #1;
        chk("pend_rsp1v", {31'd0, a_rsp1v}, 32'd1);
        chk("pend_rsp1d", a_rsp1d, 32'hDEADBEEF);

        // Reset in the middle of an outstanding load
        a_v0 = 1; a_w0 = 0; a_ad0 = 32'd3;
        #1;
        chk("rw_rdy0", {31'd0, a_rdy0}, 32'd1);
        @(negedge CLK);
        a_v0 = 0;
        #1;
        reset = 1'b1;
        #1;
        chk("rw_rsp1d_clr", a_rsp1d, 32'd0);
        @(negedge CLK);
        #1;
        chk("rw_no_rsp0v", {31'd0, a_rsp0v}, 32'd0);
        chk("rw_rsp0d",    a_rsp0d, 32'd0);
        reset = 1'b0;
        a_v0 = 1; a_w0 = 1; a_ad0 = 32'd7; a_wd0 = 32'h70;
        a_v1 = 1; a_w1 = 1; a_ad1 = 32'd8; a_wd1 = 32'h80;
        #1;
        chk("rw_win_rdy0", {31'd0, a_rdy0}, 32'd1);
        chk("rw_win_rdy1", {31'd0, a_rdy1}, 32'd0);
        chk("rw_win_addr", a_maddr, 32'd7);
        @(negedge CLK);
        a_v0 = 0;
        #1;
        chk("rw_st_rsp0v", {31'd0, a_rsp0v}, 32'd1);
        chk("rw_rdy1",     {31'd0, a_rdy1}, 32'd1);
        @(negedge CLK);
        a_v1 = 0;
        #1;
        chk("rw_st_rsp1v", {31'd0, a_rsp1v}, 32'd1);
        chk("rw_st_rsp1d", a_rsp1d, 32'd0);

        // Fixed priority: both ports store every cycle
        @(negedge CLK);
        b_v0 = 1; b_w0 = 1; b_v1 = 1; b_w1 = 1; b_ad1 = 32'd9; b_wd1 = 32'h99;
        for (int i = 0; i < 3; i++) begin
            b_ad0 = i + 1; b_wd0 = 32'h100 + i;
            #1;
            chk("fp_rdy0", {31'd0, b_rdy0}, 32'd1);
            chk("fp_rdy1", {31'd0, b_rdy1}, 32'd0);
            chk("fp_addr", b_maddr, i + 1);
            chk("fp_rsp0v", {31'd0, b_rsp0v}, (i == 0) ? 32'd0 : 32'd1);
            @(negedge CLK);
        end
        b_v0 = 0;
        #1;
        chk("fp_last_rsp0v", {31'd0, b_rsp0v}, 32'd1);
        chk("fp_p1_rdy1",    {31'd0, b_rdy1}, 32'd1);
        chk("fp_p1_addr",    b_maddr, 32'd9);
        chk("fp_p1_wdata",   b_mwdat, 32'h99);
        @(negedge CLK);
        b_v1 = 0;
        #1;
        chk("fp_rsp1v", {31'd0, b_rsp1v}, 32'd1);
        chk("fp_rsp1d", b_rsp1d, 32'd0);
        chk("fp_rsp0v_off", {31'd0, b_rsp0v}, 32'd0);

        @(negedge CLK);
        #3;
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
